// File: rtl/pipeline_hazard_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_hazard_ctrl_if
// Description : Hazard inputs and stall/flush controls between pipeline and ctrl
// Revision    : 1.0
// ============================================================================
interface pipeline_hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    logic [4:0]       IFID_RS1_i;
    logic [4:0]       IFID_RS2_i;
    logic             IDEX_MemRead_i;
    logic [4:0]       IDEX_RDaddr_i;
    logic             branch_taken_i;
    logic             mem_stall_i;
    logic             pc_write_o;
    logic             ifid_stall_o;
    logic             idex_stall_o;
    logic             exmem_stall_o;
    logic             memwb_stall_o;
    logic             idex_bubble_o;
    logic             ifid_flush_o;
    logic             err_o;
    logic [1:0]       state_o;
    logic [CNT_W-1:0] stall_cnt_o;
    logic [CNT_W-1:0] hazard_cnt_o;

    modport master (
        output IFID_RS1_i, IFID_RS2_i, IDEX_MemRead_i, IDEX_RDaddr_i,
               branch_taken_i, mem_stall_i,
        input  pc_write_o, ifid_stall_o, idex_stall_o, exmem_stall_o,
               memwb_stall_o, idex_bubble_o, ifid_flush_o, err_o, state_o,
               stall_cnt_o, hazard_cnt_o
    );

    modport slave (
        input  IFID_RS1_i, IFID_RS2_i, IDEX_MemRead_i, IDEX_RDaddr_i,
               branch_taken_i, mem_stall_i,
        output pc_write_o, ifid_stall_o, idex_stall_o, exmem_stall_o,
               memwb_stall_o, idex_bubble_o, ifid_flush_o, err_o, state_o,
               stall_cnt_o, hazard_cnt_o
    );
endinterface
`default_nettype wire

// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_hazard_ctrl
// Description : Load-use / branch / memory-freeze hazard control with timeout
// Revision    : 1.0
// ============================================================================
module pipeline_hazard_ctrl #(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 16
) (
    input  wire                    clk_i,
    input  wire                    start_i,
    pipeline_hazard_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {
        S_RUN      = 2'd0,
        S_MEM_WAIT = 2'd1,
        S_ERROR    = 2'd2
    } state_t;

    localparam logic [15:0] c_WAIT_LAST = 16'(TIMEOUT - 1);

    state_t           r_state;
    logic [15:0]      r_wait_cnt;
    logic             r_err;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_hazard_cnt;

    logic w_freeze;
    logic w_load_use;
    logic w_pc_write;
    logic w_ifid_stall;
    logic w_back_stall;
    logic w_bubble;
    logic w_flush;

    assign w_freeze = (r_state == S_ERROR) ||
                      (((r_state == S_RUN) || (r_state == S_MEM_WAIT)) && bus.mem_stall_i);

    // x0 is never a real destination, so a load into it cannot create a hazard.
    assign w_load_use = bus.IDEX_MemRead_i && (bus.IDEX_RDaddr_i != 5'd0) &&
                        ((bus.IDEX_RDaddr_i == bus.IFID_RS1_i) ||
                         (bus.IDEX_RDaddr_i == bus.IFID_RS2_i));

    always_comb begin
        w_pc_write   = 1'b1;
        w_ifid_stall = 1'b0;
        w_back_stall = 1'b0;
        w_bubble     = 1'b0;
        w_flush      = 1'b0;
        if (w_freeze) begin
            w_pc_write   = 1'b0;
            w_ifid_stall = 1'b1;
            w_back_stall = 1'b1;
        end else if (w_load_use) begin
            w_pc_write   = 1'b0;
            w_ifid_stall = 1'b1;
            w_bubble     = 1'b1;
        end else if (bus.branch_taken_i) begin
            w_flush      = 1'b1;
        end
    end

    assign bus.pc_write_o    = w_pc_write;
    assign bus.ifid_stall_o  = w_ifid_stall;
    assign bus.idex_stall_o  = w_back_stall;
    assign bus.exmem_stall_o = w_back_stall;
    assign bus.memwb_stall_o = w_back_stall;
    assign bus.idex_bubble_o = w_bubble;
    assign bus.ifid_flush_o  = w_flush;
    assign bus.err_o         = r_err;
    assign bus.state_o       = r_state;
    assign bus.stall_cnt_o   = r_stall_cnt;
    assign bus.hazard_cnt_o  = r_hazard_cnt;

    always_ff @(posedge clk_i or negedge start_i) begin
        if (!start_i) begin
            r_state    <= S_RUN;
            r_wait_cnt <= 16'd0;
            r_err      <= 1'b0;
        end else begin
            case (r_state)
                S_RUN: begin
                    if (bus.mem_stall_i) begin
                        r_state    <= S_MEM_WAIT;
                        r_wait_cnt <= r_wait_cnt + 16'd1;
                    end else begin
                        r_wait_cnt <= 16'd0;
                    end
                end
                S_MEM_WAIT: begin
                    if (!bus.mem_stall_i) begin
                        r_state    <= S_RUN;
                        r_wait_cnt <= 16'd0;
                    end else if (r_wait_cnt == c_WAIT_LAST) begin
                        r_state    <= S_ERROR;
                        r_err      <= 1'b1;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 16'd1;
                    end
                end
                S_ERROR: begin
                    r_err <= 1'b1;
                end
                default: begin
                    r_state    <= S_RUN;
                    r_wait_cnt <= 16'd0;
                end
            endcase
        end
    end

    // Saturating performance counters; they hold at all-ones instead of wrapping.
    always_ff @(posedge clk_i or negedge start_i) begin
        if (!start_i) begin
            r_stall_cnt  <= '0;
            r_hazard_cnt <= '0;
        end else begin
            if (!w_pc_write && (r_stall_cnt != {CNT_W{1'b1}}))
                r_stall_cnt <= r_stall_cnt + 1'b1;
            if (w_bubble && (r_hazard_cnt != {CNT_W{1'b1}}))
                r_hazard_cnt <= r_hazard_cnt + 1'b1;
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipeline_hazard_ctrl
// Description : Directed self-checking bench (TIMEOUT=4, CNT_W=2)
// Revision    : 1.0
// ============================================================================
module tb_pipeline_hazard_ctrl;
    logic clk_i   = 1'b0;
    logic start_i = 1'b0;
    int   checks   = 0;
    int   failures = 0;

    pipeline_hazard_ctrl_if #(.CNT_W(2)) bus ();

    pipeline_hazard_ctrl #(.TIMEOUT(4), .CNT_W(2)) dut (
        .clk_i   (clk_i),
        .start_i (start_i),
        .bus     (bus.slave)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // {pc_write, ifid_stall, idex_stall, exmem_stall, memwb_stall, bubble, flush}
    task automatic chk_ctl(input string tag, input logic [6:0] exp);
        chk(tag, {25'd0, bus.pc_write_o, bus.ifid_stall_o, bus.idex_stall_o,
                  bus.exmem_stall_o, bus.memwb_stall_o, bus.idex_bubble_o,
                  bus.ifid_flush_o}, {25'd0, exp});
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive(input logic rd_en, input logic [4:0] rd, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic br, input logic ms);
        bus.IDEX_MemRead_i = rd_en;
        bus.IDEX_RDaddr_i  = rd;
        bus.IFID_RS1_i     = rs1;
        bus.IFID_RS2_i     = rs2;
        bus.branch_taken_i = br;
        bus.mem_stall_i    = ms;
        #1;
    endtask

    localparam logic [6:0] c_NORMAL = 7'b1000000;
    localparam logic [6:0] c_FREEZE = 7'b0111100;
    localparam logic [6:0] c_BUBBLE = 7'b0100010;
    localparam logic [6:0] c_FLUSH  = 7'b1000001;

    initial begin
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        #10;
        chk("reset_state", {30'd0, bus.state_o}, 32'd0);
        chk("reset_err", {31'd0, bus.err_o}, 32'd0);
        chk("reset_cnts", {28'd0, bus.stall_cnt_o, bus.hazard_cnt_o}, 32'd0);
        chk_ctl("reset_ctl", c_NORMAL);
        tick();
        start_i = 1'b1;

        // Load-use on rs2
        drive(1'b1, 5'd5, 5'd0, 5'd5, 1'b0, 1'b0);
        chk_ctl("loaduse_ctl", c_BUBBLE);
        tick();
        chk("loaduse_hcnt", {30'd0, bus.hazard_cnt_o}, 32'd1);
        chk("loaduse_scnt", {30'd0, bus.stall_cnt_o}, 32'd1);

        // x0 destination: matches rs1/rs2 but must not stall
        drive(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        chk_ctl("x0_ctl", c_NORMAL);
        tick();
        chk("x0_hcnt", {30'd0, bus.hazard_cnt_o}, 32'd1);

        // Async reset without a clock edge, then a 3-cycle memory freeze
        #1 start_i = 1'b0;
        #1;
        chk("rst_cnts", {28'd0, bus.stall_cnt_o, bus.hazard_cnt_o}, 32'd0);
        tick();
        start_i = 1'b1;
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1);
        chk_ctl("frz_ctl0", c_FREEZE);
        chk("frz_st0", {30'd0, bus.state_o}, 32'd0);
        tick();
        chk("frz_st1", {30'd0, bus.state_o}, 32'd1);
        chk_ctl("frz_ctl1", c_FREEZE);
        tick();
        chk("frz_st2", {30'd0, bus.state_o}, 32'd1);
        chk("frz_scnt2", {30'd0, bus.stall_cnt_o}, 32'd2);
        tick();
        chk("frz_st3", {30'd0, bus.state_o}, 32'd1);
        chk_ctl("frz_ctl3", c_FREEZE);
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        chk_ctl("frz_release", c_NORMAL);
        tick();
        chk("frz_st4", {30'd0, bus.state_o}, 32'd0);
        chk("frz_scnt", {30'd0, bus.stall_cnt_o}, 32'd3);
        chk("frz_err", {31'd0, bus.err_o}, 32'd0);

        // Priority: freeze > load-use > branch
        drive(1'b1, 5'd7, 5'd7, 5'd0, 1'b1, 1'b1);
        chk_ctl("pri_freeze", c_FREEZE);
        tick();
        drive(1'b1, 5'd7, 5'd7, 5'd0, 1'b1, 1'b0);
        chk_ctl("pri_bubble", c_BUBBLE);
        tick();
        chk("pri_st", {30'd0, bus.state_o}, 32'd0);
        chk("pri_hcnt", {30'd0, bus.hazard_cnt_o}, 32'd1);
        drive(1'b0, 5'd7, 5'd7, 5'd0, 1'b1, 1'b0);
        chk_ctl("pri_flush", c_FLUSH);
        tick();

        // Timeout: ERROR after exactly 4 freeze cycles
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1);
        tick();
        tick();
        tick();
        chk("to_st3", {30'd0, bus.state_o}, 32'd1);
        chk("to_err3", {31'd0, bus.err_o}, 32'd0);
        tick();
        chk("to_st4", {30'd0, bus.state_o}, 32'd2);
        chk("to_err4", {31'd0, bus.err_o}, 32'd1);
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0);
        chk_ctl("err_ctl", c_FREEZE);
        tick();
        chk("err_sticky_st", {30'd0, bus.state_o}, 32'd2);
        chk("err_sticky", {31'd0, bus.err_o}, 32'd1);
        chk("err_scnt_sat", {30'd0, bus.stall_cnt_o}, 32'd3);

        // Reset mid-ERROR releases freeze immediately
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        start_i = 1'b0;
        #1;
        chk("rerr_st", {30'd0, bus.state_o}, 32'd0);
        chk("rerr_err", {31'd0, bus.err_o}, 32'd0);
        chk("rerr_cnts", {28'd0, bus.stall_cnt_o, bus.hazard_cnt_o}, 32'd0);
        chk_ctl("rerr_ctl", c_NORMAL);
        tick();
        start_i = 1'b1;

        // Saturation: 5 load-use cycles on rs1 with 2-bit counters
        drive(1'b1, 5'd31, 5'd31, 5'd2, 1'b0, 1'b0);
        tick();
        tick();
        chk("sat_hcnt2", {30'd0, bus.hazard_cnt_o}, 32'd2);
        tick();
        tick();
        tick();
        chk("sat_scnt", {30'd0, bus.stall_cnt_o}, 32'd3);
        chk("sat_hcnt", {30'd0, bus.hazard_cnt_o}, 32'd3);
        chk("sat_st", {30'd0, bus.state_o}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/pipeline_hazard_ctrl.md
PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 The block SHALL have the parameter TIMEOUT, default 255, giving the maximum consecutive memory-freeze cycles before the error state (legal range 2..65535).
REQ-002 The block SHALL have the parameter CNT_W, default 16, giving the width of the performance counters.
REQ-003 The block SHALL have a single clock and an asynchronous, active-low reset: the clock port is clk_i and the reset port is start_i.
REQ-004 The ports SHALL be as follows (name, direction, width, meaning):
- clk_i  in  1  clock, rising edge.
- start_i  in  1  asynchronous active-low reset.
- IFID_RS1_i  in  5  rs1 of the instruction in ID.
- IFID_RS2_i  in  5  rs2 of the instruction in ID.
- IDEX_MemRead_i  in  1  instruction in EX is a load.
- IDEX_RDaddr_i  in  5  destination register of the instruction in EX.
- branch_taken_i  in  1  branch resolved taken in ID.
- mem_stall_i  in  1  data cache busy; MEM access not complete.
- pc_write_o  out  1  PC update enable.
- ifid_stall_o  out  1  hold IF/ID.
- idex_stall_o  out  1  hold ID/EX.
- exmem_stall_o  out  1  hold EX/MEM.
- memwb_stall_o  out  1  hold MEM/WB.
- idex_bubble_o  out  1  force zero control into ID/EX.
- ifid_flush_o  out  1  clear IF/ID.
- err_o  out  1  sticky memory-timeout error.
- state_o  out  2  current FSM state.
- stall_cnt_o  out  CNT_W  saturating count of cycles with pc_write_o=0.
- hazard_cnt_o  out  CNT_W  saturating count of load-use bubbles.

Function
REQ-005 The FSM SHALL have the states RUN=2'd0, MEM_WAIT=2'd1 and ERROR=2'd2, and state_o SHALL equal the current state.
REQ-006 The internal signal freeze SHALL be 1 when (state==RUN and mem_stall_i) or (state==MEM_WAIT and mem_stall_i) or state==ERROR.
REQ-007 The internal signal load_use SHALL be 1 when IDEX_MemRead_i=1, IDEX_RDaddr_i!=0, and IDEX_RDaddr_i equals IFID_RS1_i or IFID_RS2_i.
REQ-008 All outputs except the counters, err_o and state_o SHALL be combinational from the state and the current inputs, applying in the same cycle.
REQ-009 When freeze=1, the block SHALL drive pc_write_o=0 and all four stall outputs to 1, with idex_bubble_o=0 and ifid_flush_o=0.
REQ-010 When freeze=0 and load_use=1, the block SHALL drive pc_write_o=0, ifid_stall_o=1, idex_bubble_o=1, the other stalls 0 and ifid_flush_o=0.
REQ-011 When freeze=0, load_use=0 and branch_taken_i=1, the block SHALL drive ifid_flush_o=1, pc_write_o=1 and all stalls 0.
REQ-012 Otherwise the block SHALL drive pc_write_o=1 and all stalls, idex_bubble_o and ifid_flush_o to 0.
REQ-013 The priority among these cases SHALL be freeze > load_use > branch flush.
REQ-014 A branch that is suppressed by freeze or load_use SHALL NOT be stored; the held ID instruction re-asserts branch_taken_i.
REQ-015 From RUN, the FSM SHALL go to MEM_WAIT when mem_stall_i=1 and stay in RUN otherwise.
REQ-016 From MEM_WAIT, the FSM SHALL go to RUN when mem_stall_i=0, with freeze released in that same cycle.
REQ-017 The internal counter wait_cnt SHALL count consecutive freeze cycles: it is cleared in any cycle with freeze=0 and increments while freeze=1 in RUN or MEM_WAIT.
REQ-018 From MEM_WAIT, the FSM SHALL go to ERROR when mem_stall_i=1 and wait_cnt==TIMEOUT-1, so ERROR is entered after exactly TIMEOUT freeze cycles.
REQ-019 ERROR SHALL be terminal until reset, with err_o=1 registered on entry and mem_stall_i ignored.
REQ-020 stall_cnt_o SHALL increment on each rising edge where pc_write_o=0 and saturate at 2^CNT_W-1.
REQ-021 hazard_cnt_o SHALL increment on each rising edge where idex_bubble_o=1 and saturate at 2^CNT_W-1.
REQ-022 The block SHALL have no counter wrap-around in any state.

Reset
REQ-023 When start_i=0, the block SHALL asynchronously force state=RUN, wait_cnt=0, err_o=0, stall_cnt_o=0 and hazard_cnt_o=0, regardless of the clock.
REQ-024 A reset asserted mid-freeze or in ERROR SHALL immediately release freeze, with combinational outputs following the inputs per RUN.
REQ-025 After start_i deasserts, the first rising edge SHALL operate normally.

Verification
REQ-026 Load-use: IDEX_MemRead_i=1, IDEX_RDaddr_i=5, IFID_RS2_i=5 for one cycle -> pc_write_o=0, ifid_stall_o=1, idex_bubble_o=1, and hazard_cnt_o 0->1.
REQ-027 x0 exemption: the same stimulus with IDEX_RDaddr_i=0 -> no stall, no bubble, and hazard_cnt_o unchanged.
REQ-028 Memory freeze: mem_stall_i=1 for 3 cycles then 0 -> all stalls=1 for exactly 3 cycles, state_o 0->1->1->1->0, and stall_cnt_o +3.
REQ-029 Priority: mem_stall_i=1, load_use=1 and branch_taken_i=1 together -> freeze outputs only; after mem_stall_i=0 -> bubble with flush still 0; after the hazard clears and the branch re-asserts -> ifid_flush_o=1.
REQ-030 Timeout: with TIMEOUT=4 and mem_stall_i held at 1 -> state_o=2 after the 4th freeze cycle, err_o=1 sticky, and stalls stay 1 after mem_stall_i=0.
REQ-031 Reset mid-ERROR and counter saturation: start_i pulsed low -> state_o=0, err_o=0, counters 0 without a clock edge; with CNT_W=2, 5 stall cycles -> stall_cnt_o=3.
